// File: rtl/xor_frame_accumulator.sv
// xor_frame_accumulator: XORs a stream of (a, b) operand pairs and packs FRAME_LEN
// consecutive results into a frame. Each frame is reported with its ones count and parity.
//
// Ports:
//   clk, rst             rising-edge clock; asynchronous active-low reset
//   clear                synchronous abort of the partial frame and any pending output
//   a, b                 XOR operands
//   in_valid, in_ready   input handshake (in_ready is combinational in HOLD)
//   out_valid, out_ready output handshake
//   out_bits             frame bits; bit i holds the i-th accepted pair of the frame
//   out_ones             number of ones in out_bits
//   out_parity           XOR-reduction of out_bits
module xor_frame_accumulator #(
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 a,
  input  logic                 b,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FRAME_LEN-1:0] out_bits,
  output logic [CNT_W-1:0]     out_ones,
  output logic                 out_parity
);

  localparam int unsigned IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [FRAME_LEN-1:0] acc_bits_q, acc_bits_d;
  logic [CNT_W-1:0]     ones_q, ones_d;
  logic                 par_q, par_d;
  logic [FRAME_LEN-1:0] out_bits_q, out_bits_d;
  logic [CNT_W-1:0]     out_ones_q, out_ones_d;
  logic                 out_par_q, out_par_d;

  logic                 x;
  logic                 in_acc;
  logic                 out_acc;
  logic [FRAME_LEN-1:0] bits_ins;
  logic [CNT_W-1:0]     ones_ins;
  logic                 par_ins;

  // Handshake decode; in HOLD the input is only open while the frame is being taken.
  assign in_ready   = (state_q == COLLECT) ? 1'b1 : out_ready;
  assign out_valid  = (state_q == HOLD);
  assign out_bits   = out_bits_q;
  assign out_ones   = out_ones_q;
  assign out_parity = out_par_q;

  assign x       = a ^ b;
  assign in_acc  = in_valid && in_ready;
  assign out_acc = out_valid && out_ready;

  // Accumulators with the current result folded in; the target bit is always 0 beforehand.
  assign bits_ins = acc_bits_q | (FRAME_LEN'(x) << idx_q);
  assign ones_ins = ones_q + CNT_W'(x);
  assign par_ins  = par_q ^ x;

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= COLLECT;
      idx_q      <= '0;
      acc_bits_q <= '0;
      ones_q     <= '0;
      par_q      <= 1'b0;
      out_bits_q <= '0;
      out_ones_q <= '0;
      out_par_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acc_bits_q <= acc_bits_d;
      ones_q     <= ones_d;
      par_q      <= par_d;
      out_bits_q <= out_bits_d;
      out_ones_q <= out_ones_d;
      out_par_q  <= out_par_d;
    end
  end

  // Next-state logic. In HOLD the accumulators and idx are already zero, so a pair
  // accepted during hand-off takes the same path as one accepted in COLLECT.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_bits_d = acc_bits_q;
    ones_d     = ones_q;
    par_d      = par_q;
    out_bits_d = out_bits_q;
    out_ones_d = out_ones_q;
    out_par_d  = out_par_q;

    if (clear) begin
      state_d    = COLLECT;
      idx_d      = '0;
      acc_bits_d = '0;
      ones_d     = '0;
      par_d      = 1'b0;
    end else if (in_acc) begin
      if (idx_q == IDX_LAST) begin
        out_bits_d = bits_ins;
        out_ones_d = ones_ins;
        out_par_d  = par_ins;
        idx_d      = '0;
        acc_bits_d = '0;
        ones_d     = '0;
        par_d      = 1'b0;
        state_d    = HOLD;
      end else begin
        acc_bits_d = bits_ins;
        ones_d     = ones_ins;
        par_d      = par_ins;
        idx_d      = idx_q + IDX_W'(1);
        state_d    = COLLECT;
      end
    end else if (out_acc) begin
      state_d = COLLECT;
    end
  end

endmodule
